vga_timing: RTL and testbench

- Raster timing generator for the VGA output path.
- Produces the horizontal/vertical pixel counters and the active-area enable (EA) consumed by the pixel colour stage, plus hsync/vsync for the connector pins and frame/line strobes for game logic.
- Default mode: 800x600@72 Hz at a 50 MHz pixel rate.
- Counters advance only on pixel-enable ticks, so a faster system clock is supported.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing.sv | 114 +++++++++++
 tb/tb_vga_timing.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants and types for the VGA timing generator.
package vga_pkg;

    typedef logic [10:0] vga_coord_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

    // 800x600@72 Hz, 50 MHz pixel rate
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 56;
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BP     = 64;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 37;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BP     = 23;

    // 640x480@60 Hz, 25.175 MHz pixel rate
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int COORD_LIMIT = 2048;

    function automatic int axis_total(input int act, input int fp, input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- position counter, phase FSM and sync level.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACT_LEN  = SVGA_H_ACTIVE,
    parameter int   FP_LEN   = SVGA_H_FP,
    parameter int   SYNC_LEN = SVGA_H_SYNC,
    parameter int   BP_LEN   = SVGA_H_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output vga_coord_t count,
    output vga_phase_t phase,
    output logic       sync,
    output logic       wrap
);

    localparam int         TOTAL    = axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
    localparam vga_coord_t LAST     = vga_coord_t'(TOTAL - 1);
    localparam vga_coord_t END_ACT  = vga_coord_t'(ACT_LEN - 1);
    localparam vga_coord_t END_FP   = vga_coord_t'(ACT_LEN + FP_LEN - 1);
    localparam vga_coord_t END_SYNC = vga_coord_t'(ACT_LEN + FP_LEN + SYNC_LEN - 1);

    vga_coord_t count_next;
    vga_phase_t phase_next;

    assign wrap = step && (count == LAST);

    // Phase changes on the tick that leaves the last count of the current phase.
    always_comb begin
        count_next = (count == LAST) ? '0 : count + 11'd1;
        phase_next = (count == LAST)     ? ACTIVE :
                     (count == END_ACT)  ? FRONT  :
                     (count == END_FP)   ? SYNC   :
                     (count == END_SYNC) ? BACK   : phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
            phase <= BACK;
            sync  <= ~SYNC_POL;
        end else if (step) begin
            count <= count_next;
            phase <= phase_next;
            sync  <= (phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator (counters, EA, syncs, line/frame strobes).
// Define VGA_TIMING_SYNC_DELAY_EN to delay hsync/vsync by one pixel to match a registered colour stage.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   H_FP     = SVGA_H_FP,
    parameter int   H_SYNC   = SVGA_H_SYNC,
    parameter int   H_BP     = SVGA_H_BP,
    parameter int   V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   V_FP     = SVGA_V_FP,
    parameter int   V_SYNC   = SVGA_V_SYNC,
    parameter int   V_BP     = SVGA_V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] count_h,
    output logic [10:0] count_v,
    output logic        EA,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int         H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int         V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam vga_coord_t H_END_ACT = vga_coord_t'(H_ACTIVE - 1);
    localparam vga_coord_t V_END_ACT = vga_coord_t'(V_ACTIVE - 1);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_width
        $error("vga_timing: porch, sync and active widths must all be non-zero");
    end
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_too_wide
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    vga_coord_t h_count, v_count;
    vga_phase_t h_phase, v_phase;
    logic       h_sync, v_sync, h_wrap, v_wrap;
    logic       h_act_next, v_act_next;

    vga_axis_counter #(
        .ACT_LEN (H_ACTIVE),
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP),
        .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk  (clk),
        .rst_n(rst_n),
        .step (pix_en),
        .count(h_count),
        .phase(h_phase),
        .sync (h_sync),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .ACT_LEN (V_ACTIVE),
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk  (clk),
        .rst_n(rst_n),
        .step (h_wrap),
        .count(v_count),
        .phase(v_phase),
        .sync (v_sync),
        .wrap (v_wrap)
    );

    // EA is registered from the look-ahead so it lines up with the counts it describes.
    always_comb begin
        h_act_next = h_wrap || (h_phase == ACTIVE && h_count != H_END_ACT);
        v_act_next = v_wrap || (v_phase == ACTIVE && !(h_wrap && v_count == V_END_ACT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EA          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            EA          <= pix_en ? (h_act_next && v_act_next) : EA;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

    assign count_h = h_count;
    assign count_v = v_count;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (pix_en) begin
            hsync <= h_sync;
            vsync <= v_sync;
        end
    end
`else
    assign hsync = h_sync;
    assign vsync = v_sync;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing in the default mode and a small-raster instance for frame timing.
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b1;

    logic [10:0] ch, cv, s_ch, s_cv;
    logic        ea, hs, vs, ls, fs;
    logic        s_ea, s_hs, s_vs, s_ls, s_fs;

    int tests_run = 0;
    int fails = 0;
    int hold_err = 0;
    bit tog = 1'b0;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int HS_FIRST = 857;
`else
    localparam int HS_FIRST = 856;
`endif

    always #5 clk = ~clk;

    vga_timing u_svga (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .count_h    (ch),
        .count_v    (cv),
        .EA         (ea),
        .hsync      (hs),
        .vsync      (vs),
        .line_start (ls),
        .frame_start(fs)
    );

    // 25 x 14 raster: hsync at h in [18,20], vsync at v in [9,10]
    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .count_h    (s_ch),
        .count_v    (s_cv),
        .EA         (s_ea),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .line_start (s_ls),
        .frame_start(s_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [10:0] ph;
        logic        phs, pea;
        ph = ch;
        phs = hs;
        pea = ea;
        if (tog) pix_en = ~pix_en;
        @(posedge clk);
        #1;
        if (tog && !pix_en && (ch !== ph || hs !== phs || ea !== pea ||
                               ls !== 1'b0 || fs !== 1'b0 || s_ls !== 1'b0 || s_fs !== 1'b0))
            hold_err++;
    endtask

    task automatic measure_line(input int m);
        int n, ea_n, hs_n, first;
        for (int i = 0; i < 3000 && !ls; i++) step();
        check("line_start_seen", int'(ls), 1);
        n = 0; ea_n = 0; hs_n = 0; first = -1;
        do begin
            ea_n += int'(ea);
            if (hs) begin
                hs_n++;
                if (first < 0) first = int'(ch);
            end
            step();
            n++;
        end while (!ls && n < 5000);
        check("line_period", n, 1040 * m);
        check("line_ea_clocks", ea_n, 800 * m);
        check("line_hsync_clocks", hs_n, 120 * m);
        check("hsync_first_h", first, HS_FIRST);
    endtask

    task automatic measure_frame(input int m);
        int n, ea_n, vs_n, first;
        for (int i = 0; i < 2000 && !s_fs; i++) step();
        check("frame_start_seen", int'(s_fs), 1);
        n = 0; ea_n = 0; vs_n = 0; first = -1;
        do begin
            ea_n += int'(s_ea);
            if (s_vs) begin
                vs_n++;
                if (first < 0) first = int'(s_cv);
            end
            step();
            n++;
        end while (!s_fs && n < 3000);
        check("frame_period", n, 350 * m);
        check("frame_ea_clocks", ea_n, 128 * m);
        check("frame_vsync_clocks", vs_n, 50 * m);
        check("vsync_first_v", first, 9);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_count_h", int'(ch), 1039);
        check("rst_count_v", int'(cv), 665);
        check("rst_ea", int'(ea), 0);
        check("rst_hsync", int'(hs), 0);
        check("rst_vsync", int'(vs), 0);
        check("rst_line_start", int'(ls), 0);
        check("rst_frame_start", int'(fs), 0);
        check("rst_small_h", int'(s_ch), 24);
        check("rst_small_v", int'(s_cv), 13);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_count_h", int'(ch), 0);
        check("first_count_v", int'(cv), 0);
        check("first_ea", int'(ea), 1);
        check("first_frame_start", int'(fs), 1);
        check("first_line_start", int'(ls), 1);
        check("first_hsync", int'(hs), 0);
        check("first_small_h", int'(s_ch), 0);
        step();
        check("second_frame_start", int'(fs), 0);
        check("second_line_start", int'(ls), 0);
        check("second_count_h", int'(ch), 1);

        measure_line(1);
        measure_frame(1);

        tog = 1'b1;
        measure_line(2);
        measure_frame(2);
        check("hold_while_idle", hold_err, 0);

        tog = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 2100 && ch != 11'd900; i++) step();
        check("reach_h900", int'(ch), 900);
        check("hsync_at_h900", int'(hs), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_hsync", int'(hs), 0);
        check("async_rst_count_h", int'(ch), 1039);
        check("async_rst_count_v", int'(cv), 665);
        check("async_rst_ea", int'(ea), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
